// File: rtl/pipe_stage_bank.sv
// Parametrised inter-stage pipeline register bank with a valid/ready handshake,
// synchronous flush, optional 2-entry skid buffer and saturating stall/flush counters.
module pipe_stage_bank #(
  parameter int unsigned CTRL_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned N_DATA  = 4,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned N_ADDR  = 3,
  parameter int unsigned SKID_EN = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic [N_DATA*DATA_W-1:0] in_data,
  input  logic [N_ADDR*ADDR_W-1:0] in_addr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [N_DATA*DATA_W-1:0] out_data,
  output logic [N_ADDR*ADDR_W-1:0] out_addr,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         flush_cnt
);

  localparam int unsigned EntryW = CTRL_W + N_DATA * DATA_W + N_ADDR * ADDR_W;

  logic [EntryW-1:0] in_entry;
  logic [EntryW-1:0] main_q, main_d;
  logic              main_vld_q, main_vld_d;
  logic              held_any;
  logic              in_fire, out_fire;

  assign in_entry = {in_ctrl, in_data, in_addr};
  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_vld_q & out_ready;

  assign out_valid = main_vld_q;
  assign {out_ctrl, out_data, out_addr} = main_vld_q ? main_q : '0;

  if (SKID_EN != 0) begin : gen_skid
    logic [EntryW-1:0] skid_q, skid_d;
    logic              skid_vld_q, skid_vld_d;

    // Skid only fills while main is full, so in_ready can be a plain flop output.
    assign in_ready = ~skid_vld_q;
    assign held_any = main_vld_q | skid_vld_q;

    always_comb begin
      main_vld_d = main_vld_q;
      main_d     = main_q;
      skid_vld_d = skid_vld_q;
      skid_d     = skid_q;
      if (flush) begin
        main_vld_d = 1'b0;
        main_d     = '0;
        skid_vld_d = 1'b0;
        skid_d     = '0;
      end else if (!main_vld_q || out_fire) begin
        if (skid_vld_q) begin
          main_vld_d = 1'b1;
          main_d     = skid_q;
          skid_vld_d = in_fire;
          skid_d     = in_fire ? in_entry : '0;
        end else begin
          main_vld_d = in_fire;
          main_d     = in_fire ? in_entry : '0;
        end
      end else if (in_fire) begin
        skid_vld_d = 1'b1;
        skid_d     = in_entry;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        skid_vld_q <= 1'b0;
        skid_q     <= '0;
      end else begin
        skid_vld_q <= skid_vld_d;
        skid_q     <= skid_d;
      end
    end
  end else begin : gen_no_skid
    assign in_ready = ~main_vld_q | out_ready;
    assign held_any = main_vld_q;

    always_comb begin
      main_vld_d = main_vld_q;
      main_d     = main_q;
      if (flush) begin
        main_vld_d = 1'b0;
        main_d     = '0;
      end else if (in_ready) begin
        main_vld_d = in_fire;
        main_d     = in_fire ? in_entry : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_vld_q <= 1'b0;
      main_q     <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      main_q     <= main_d;
    end
  end

  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (main_vld_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (flush && held_any && (flush_q != {CNT_W{1'b1}})) begin
      flush_d = flush_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_stage_bank.sv
// Self-checking bench for pipe_stage_bank: skid-mode DUT with a scoreboard monitor,
// plus a no-skid DUT with a 4-bit counter for saturation and combinational-ready checks.
module tb_pipe_stage_bank;

  localparam int CW = 10;
  localparam int DW = 32;
  localparam int ND = 4;
  localparam int AW = 5;
  localparam int NA = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Skid-mode DUT
  logic               flush, in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0]      in_ctrl, out_ctrl;
  logic [ND*DW-1:0]   in_data, out_data;
  logic [NA*AW-1:0]   in_addr, out_addr;
  logic [15:0]        stall_cnt, flush_cnt;

  // No-skid DUT
  logic               b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [CW-1:0]      b_in_ctrl, b_out_ctrl;
  logic [ND*DW-1:0]   b_in_data, b_out_data;
  logic [NA*AW-1:0]   b_in_addr, b_out_addr;
  logic [3:0]         b_stall_cnt, b_flush_cnt;

  pipe_stage_bank #(.SKID_EN(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .out_addr(out_addr),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_stage_bank #(.SKID_EN(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_ctrl(b_in_ctrl), .in_data(b_in_data), .in_addr(b_in_addr),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_ctrl(b_out_ctrl), .out_data(b_out_data), .out_addr(b_out_addr),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  typedef struct packed {
    logic [CW-1:0]    c;
    logic [ND*DW-1:0] d;
    logic [NA*AW-1:0] a;
  } ent_t;

  ent_t        sb[$];
  ent_t        mon_e;
  int          mon_held;
  logic [15:0] exp_stall, exp_flush;
  int          checks = 0;
  int          passed = 0;

  // Scoreboard monitor: samples 1 time unit before each rising edge.
  always @(negedge clk) begin
    #4;
    if (!rst) begin
      sb.delete();
      exp_stall = '0;
      exp_flush = '0;
      checks++;
      if (out_valid !== 1'b0 || out_ctrl !== '0 || stall_cnt !== '0 || flush_cnt !== '0)
        $display("FAIL in_reset: valid=%b ctrl=%h stall=%0d flush=%0d want all 0",
                 out_valid, out_ctrl, stall_cnt, flush_cnt);
      else passed++;
    end else begin
      mon_held = sb.size();
      checks++;
      if (stall_cnt !== exp_stall || flush_cnt !== exp_flush)
        $display("FAIL counters: stall=%0d flush=%0d want stall=%0d flush=%0d",
                 stall_cnt, flush_cnt, exp_stall, exp_flush);
      else passed++;
      checks++;
      if (out_valid !== (mon_held > 0))
        $display("FAIL out_valid: got %b want %b", out_valid, mon_held > 0);
      else passed++;
      if (out_valid && out_ready && mon_held > 0) begin
        mon_e = sb.pop_front();
        checks++;
        if (out_ctrl !== mon_e.c || out_data !== mon_e.d || out_addr !== mon_e.a)
          $display("FAIL sb_entry: got ctrl=%h addr=%h want ctrl=%h addr=%h",
                   out_ctrl, out_addr, mon_e.c, mon_e.a);
        else passed++;
      end else if (!out_valid) begin
        checks++;
        if (out_ctrl !== '0) $display("FAIL bubble_ctrl: got %h want 0", out_ctrl);
        else passed++;
      end
      if (out_valid && !out_ready && exp_stall != 16'hFFFF) exp_stall++;
      if (flush) begin
        if (mon_held > 0 && exp_flush != 16'hFFFF) exp_flush++;
        sb.delete();
      end else if (in_valid && in_ready) begin
        sb.push_back('{c: in_ctrl, d: in_data, a: in_addr});
      end
    end
  end

  task automatic put(input logic v, input logic [CW-1:0] c);
    in_valid = v;
    in_ctrl  = c;
    in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_addr  = 15'($urandom());
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_ctrl !== '0)
      $display("FAIL reset_state: in_ready=%b out_valid=%b ctrl=%h want 1/0/0",
               in_ready, out_valid, out_ctrl);
    else passed++;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || stall_cnt !== '0 || flush_cnt !== '0)
      $display("FAIL reset_idle: in_ready=%b stall=%0d flush=%0d want 1/0/0",
               in_ready, stall_cnt, flush_cnt);
    else passed++;
  endtask

  task automatic test_pass_through;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      put(1'b1, CW'(i));
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_ctrl !== CW'(i) || in_ready !== 1'b1)
        $display("FAIL pass_through: valid=%b ctrl=%0d in_ready=%b want 1/%0d/1",
                 out_valid, out_ctrl, in_ready, i);
      else passed++;
    end
    put(1'b0, '0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL pass_drain: valid=%b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    put(1'b1, 10'h0A1);
    @(negedge clk);
    checks++;
    if (out_ctrl !== 10'h0A1 || in_ready !== 1'b1)
      $display("FAIL bp_a: ctrl=%h in_ready=%b want 0a1/1", out_ctrl, in_ready);
    else passed++;
    put(1'b1, 10'h0B2);
    @(negedge clk);
    put(1'b1, 10'h0C3);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_ctrl !== 10'h0A1 || in_ready !== 1'b0)
        $display("FAIL bp_hold: ctrl=%h in_ready=%b want 0a1/0", out_ctrl, in_ready);
      else passed++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_ctrl !== 10'h0B2 || in_ready !== 1'b1)
      $display("FAIL bp_b: ctrl=%h in_ready=%b want 0b2/1", out_ctrl, in_ready);
    else passed++;
    @(negedge clk);
    put(1'b0, '0);
    checks++;
    if (out_ctrl !== 10'h0C3) $display("FAIL bp_c: ctrl=%h want 0c3", out_ctrl);
    else passed++;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || stall_cnt !== 16'd4)
      $display("FAIL bp_stall: valid=%b stall=%0d want 0/4", out_valid, stall_cnt);
    else passed++;
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    put(1'b1, 10'h011);
    @(negedge clk);
    put(1'b1, 10'h022);
    @(negedge clk);
    flush = 1'b1;
    put(1'b1, 10'h3FF);
    @(negedge clk);
    flush = 1'b0;
    put(1'b0, '0);
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || flush_cnt !== 16'd1 || in_ready !== 1'b1)
      $display("FAIL flush_full: valid=%b ctrl=%h flush=%0d in_ready=%b want 0/0/1/1",
               out_valid, out_ctrl, flush_cnt, in_ready);
    else passed++;
    // Single held entry, flushed while a new input actually fires
    put(1'b1, 10'h033);
    @(negedge clk);
    flush = 1'b1;
    put(1'b1, 10'h3FF);
    @(negedge clk);
    flush = 1'b0;
    put(1'b0, '0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || flush_cnt !== 16'd2)
      $display("FAIL flush_fire: valid=%b flush=%0d want 0/2", out_valid, flush_cnt);
    else passed++;
    // Flush on an empty bank is not counted
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (flush_cnt !== 16'd2) $display("FAIL flush_empty: flush=%0d want 2", flush_cnt);
    else passed++;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 300; i++) begin
      put($urandom_range(0, 9) < 7, CW'($urandom()));
      out_ready = $urandom_range(0, 9) < 6;
      flush     = $urandom_range(0, 49) == 0;
      @(negedge clk);
    end
    put(1'b0, '0);
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0)
      $display("FAIL b2b_drain: left=%0d valid=%b want 0/0", sb.size(), out_valid);
    else passed++;
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    put(1'b1, 10'h055);
    @(negedge clk);
    put(1'b1, 10'h066);
    @(negedge clk);
    put(1'b0, '0);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0 || stall_cnt !== '0 ||
        flush_cnt !== '0)
      $display("FAIL reset_mid: valid=%b ctrl=%h stall=%0d flush=%0d want all 0",
               out_valid, out_ctrl, stall_cnt, flush_cnt);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_release: in_ready=%b valid=%b want 1/0", in_ready, out_valid);
    else passed++;
    out_ready = 1'b1;
  endtask

  task automatic test_saturation;
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    b_in_ctrl   = 10'h2AA;
    @(negedge clk);
    b_in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checks++;
      if (b_stall_cnt !== 4'((k > 15) ? 15 : k))
        $display("FAIL sat_stall: k=%0d got %0d want %0d", k, b_stall_cnt,
                 (k > 15) ? 15 : k);
      else passed++;
    end
    checks++;
    if (b_out_valid !== 1'b1 || b_out_ctrl !== 10'h2AA)
      $display("FAIL sat_hold: valid=%b ctrl=%h want 1/2aa", b_out_valid, b_out_ctrl);
    else passed++;
  endtask

  task automatic test_no_skid;
    checks++;
    if (b_in_ready !== 1'b0) $display("FAIL noskid_stall: in_ready=%b want 0", b_in_ready);
    else passed++;
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_in_ctrl   = 10'h155;
    #1;
    checks++;
    if (b_in_ready !== 1'b1) $display("FAIL noskid_comb: in_ready=%b want 1", b_in_ready);
    else passed++;
    @(negedge clk);
    b_in_valid = 1'b0;
    checks++;
    if (b_out_valid !== 1'b1 || b_out_ctrl !== 10'h155 || b_stall_cnt !== 4'd15)
      $display("FAIL noskid_replace: valid=%b ctrl=%h stall=%0d want 1/155/15",
               b_out_valid, b_out_ctrl, b_stall_cnt);
    else passed++;
    @(negedge clk);
    checks++;
    if (b_out_valid !== 1'b0 || b_out_ctrl !== '0)
      $display("FAIL noskid_drain: valid=%b ctrl=%h want 0/0", b_out_valid, b_out_ctrl);
    else passed++;
  endtask

  initial begin
    flush = 1'b0; out_ready = 1'b1;
    put(1'b0, '0);
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1; b_in_ctrl = '0;
    b_in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    b_in_addr = 15'($urandom());
    test_reset();
    test_pass_through();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    test_no_skid();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
